move_sequencer: RTL and testbench

- Sequences one player move on the 2048 board.
- For each of the 4 lines in the chosen direction it reads the 4 cells, sends the line through a shared line-merge unit over a valid/ready handshake, and writes the result back.
- After the 4 lines it spawns a new tile if the board changed, then scans the board for win/lose.
- Sits between the top-level game FSM (move requests) and the board register file plus merge datapath.

---
 rtl/move_sequencer_if.sv | 33 +++
 rtl/move_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - move request, board port and merge-unit handshake bundle
interface move_sequencer_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [3:0]  cell_addr;
    logic [3:0]  cell_rdata;
    logic        cell_we;
    logic [3:0]  cell_wdata;
    logic        mrg_in_valid;
    logic [15:0] mrg_in_line;
    logic        mrg_in_ready;
    logic        mrg_out_valid;
    logic [15:0] mrg_out_line;
    logic        mrg_out_ready;
    logic [3:0]  rnd;
    logic        done;
    logic        changed;
    logic        win;
    logic        lose;

    modport master (
        input  move_valid, move_dir, cell_rdata, mrg_in_ready, mrg_out_valid, mrg_out_line, rnd,
        output move_ready, cell_addr, cell_we, cell_wdata, mrg_in_valid, mrg_in_line,
               mrg_out_ready, done, changed, win, lose
    );

    modport slave (
        output move_valid, move_dir, cell_rdata, mrg_in_ready, mrg_out_valid, mrg_out_line, rnd,
        input  move_ready, cell_addr, cell_we, cell_wdata, mrg_in_valid, mrg_in_line,
               mrg_out_ready, done, changed, win, lose
    );
endinterface

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - sequences one 2048 move: 4 lines through the merge unit, spawn, win/lose scan
module move_sequencer #(
    parameter int WIN_EXP = 11
) (
    input  logic              clk,
    input  logic              rst,
    move_sequencer_if.master  bus
);
    localparam logic [3:0] WIN_V = WIN_EXP[3:0];

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_SEND, S_RECV, S_WRITE, S_SPAWN, S_CHECK, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  line_q, line_d;
    logic [1:0]  k_q, k_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  p_q, p_d;
    logic [15:0] buf_q, buf_d;
    logic [63:0] shadow_q, shadow_d;
    logic        changed_q, changed_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;

    logic [3:0]  line_addr;
    logic        win_eval, lose_eval, any_zero, any_pair;

    // Element 0 is always the end tiles merge toward; ~k is 3-k in two bits.
    always_comb begin
        case (dir_q)
            2'b00:   line_addr = {k_q, line_q};
            2'b01:   line_addr = {~k_q, line_q};
            2'b10:   line_addr = {line_q, k_q};
            default: line_addr = {line_q, ~k_q};
        endcase
    end

    always_comb begin
        win_eval = 1'b0;
        any_zero = 1'b0;
        any_pair = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (shadow_q[4*i +: 4] == WIN_V) win_eval = 1'b1;
            if (shadow_q[4*i +: 4] == 4'd0)  any_zero = 1'b1;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (shadow_q[16*r+4*c +: 4] == shadow_q[16*r+4*c+4 +: 4]) any_pair = 1'b1;
        for (int i = 0; i < 12; i++)
            if (shadow_q[4*i +: 4] == shadow_q[4*i+16 +: 4]) any_pair = 1'b1;
        lose_eval = !win_eval && !any_zero && !any_pair;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= 2'd0;
            line_q    <= 2'd0;
            k_q       <= 2'd0;
            cnt_q     <= 5'd0;
            p_q       <= 4'd0;
            buf_q     <= 16'd0;
            shadow_q  <= 64'd0;
            changed_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            line_q    <= line_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            buf_q     <= buf_d;
            shadow_q  <= shadow_d;
            changed_q <= changed_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        line_d    = line_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        buf_d     = buf_q;
        shadow_d  = shadow_q;
        changed_d = changed_q;
        win_d     = win_q;
        lose_d    = lose_q;
        case (state_q)
            S_IDLE: begin
                if (bus.move_valid) begin
                    dir_d     = bus.move_dir;
                    changed_d = 1'b0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                    line_d    = 2'd0;
                    k_d       = 2'd0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                buf_d[4*k_q +: 4] = bus.cell_rdata;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.mrg_in_ready) state_d = S_RECV;
            end
            S_RECV: begin
                if (bus.mrg_out_valid) begin
                    buf_d = bus.mrg_out_line;
                    if (bus.mrg_out_line != buf_q) changed_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    cnt_d = 5'd0;
                    if (line_q != 2'd3) begin
                        line_d  = line_q + 2'd1;
                        state_d = S_READ;
                    end else if (changed_q) begin
                        p_d     = bus.rnd;
                        state_d = S_SPAWN;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_SPAWN: begin
                if (bus.cell_rdata == 4'd0 || cnt_q == 5'd15) begin
                    cnt_d   = 5'd0;
                    state_d = S_CHECK;
                end else begin
                    p_d   = p_q + 4'd1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_CHECK: begin
                // cnt 0..15 fills the shadow, cnt 16 is the evaluation cycle.
                if (cnt_q == 5'd16) begin
                    win_d   = win_eval;
                    lose_d  = lose_eval;
                    state_d = S_DONE;
                end else begin
                    shadow_d[4*cnt_q[3:0] +: 4] = bus.cell_rdata;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.move_ready    = (state_q == S_IDLE);
        bus.cell_addr     = 4'd0;
        bus.cell_we       = 1'b0;
        bus.cell_wdata    = 4'd0;
        bus.mrg_in_valid  = 1'b0;
        bus.mrg_out_ready = 1'b0;
        bus.done          = 1'b0;
        case (state_q)
            S_READ:  bus.cell_addr = line_addr;
            S_SEND:  bus.mrg_in_valid = 1'b1;
            S_RECV:  bus.mrg_out_ready = 1'b1;
            S_WRITE: begin
                bus.cell_addr  = line_addr;
                bus.cell_we    = 1'b1;
                bus.cell_wdata = buf_q[4*k_q +: 4];
            end
            S_SPAWN: begin
                bus.cell_addr = p_q;
                if (bus.cell_rdata == 4'd0) begin
                    bus.cell_we    = 1'b1;
                    bus.cell_wdata = 4'd1;
                end
            end
            S_CHECK: bus.cell_addr = cnt_q[3:0];
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mrg_in_line = buf_q;
    assign bus.changed     = changed_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - bench for move_sequencer with board memory, merge unit and 2048 reference model
module tb_move_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_sequencer_if ifc ();
    move_sequencer #(.WIN_EXP(11)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int tests = 0;
    int fails = 0;

    logic [3:0] brd [16];
    logic [3:0] init_brd [16];
    logic       load = 1'b0;
    int         we_count = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) brd[i] <= init_brd[i];
        end else if (ifc.cell_we) begin
            brd[ifc.cell_addr] <= ifc.cell_wdata;
            we_count <= we_count + 1;
        end
    end
    assign ifc.cell_rdata = brd[ifc.cell_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Real 2048 line merge toward element 0: compact, merge each pair once, pad with empties.
    function automatic logic [15:0] merge_ref(input logic [15:0] line);
        int v[$];
        int o[4];
        int idx, i;
        logic [15:0] res;
        for (int k = 0; k < 4; k++)
            if (line[4*k +: 4] != 4'd0) v.push_back(int'(line[4*k +: 4]));
        o = '{0, 0, 0, 0};
        idx = 0;
        i = 0;
        while (i < v.size()) begin
            if (i + 1 < v.size() && v[i] == v[i+1]) begin
                o[idx] = v[i] + 1;
                i += 2;
            end else begin
                o[idx] = v[i];
                i += 1;
            end
            idx++;
        end
        res = 16'd0;
        for (int k = 0; k < 4; k++) res[4*k +: 4] = 4'(o[k]);
        return res;
    endfunction

    // Merge unit emulation: optional stall on mrg_in_ready, then one-cycle result.
    int          stall_next = 0;
    int          n_lines_seen = 0;
    logic [15:0] first_line = 16'd0;
    logic [15:0] held;
    initial begin
        ifc.mrg_in_ready  = 1'b0;
        ifc.mrg_out_valid = 1'b0;
        ifc.mrg_out_line  = 16'd0;
        forever begin
            @(negedge clk);
            if (ifc.mrg_in_valid === 1'b1) begin
                held = ifc.mrg_in_line;
                if (n_lines_seen == 0) first_line = held;
                n_lines_seen++;
                for (int s = 0; s < stall_next; s++) begin
                    @(negedge clk);
                    check("in_stable", {47'd0, ifc.mrg_in_valid, ifc.mrg_in_line}, {47'd0, 1'b1, held});
                end
                stall_next = 0;
                ifc.mrg_in_ready = 1'b1;
                @(negedge clk);
                ifc.mrg_in_ready = 1'b0;
                check("out_ready", ifc.mrg_out_ready, 1);
                ifc.mrg_out_valid = 1'b1;
                ifc.mrg_out_line  = merge_ref(held);
                @(negedge clk);
                ifc.mrg_out_valid = 1'b0;
            end
        end
    end

    logic [3:0] exp_brd [16];
    bit         exp_changed, exp_win, exp_lose, exp_spawned;
    int         exp_probes;

    function automatic int cell_index(input logic [1:0] dir, input int l, input int k);
        int row, col;
        case (dir)
            2'b00:   begin row = k;     col = l;     end
            2'b01:   begin row = 3 - k; col = l;     end
            2'b10:   begin row = l;     col = k;     end
            default: begin row = l;     col = 3 - k; end
        endcase
        return row * 4 + col;
    endfunction

    task automatic model_move(input logic [1:0] dir, input logic [3:0] rn);
        logic [15:0] ln, mg;
        bit zero, pair;
        logic [3:0] v;
        for (int i = 0; i < 16; i++) exp_brd[i] = brd[i];
        exp_changed = 0;
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 4; k++) ln[4*k +: 4] = exp_brd[cell_index(dir, l, k)];
            mg = merge_ref(ln);
            if (mg != ln) exp_changed = 1;
            for (int k = 0; k < 4; k++) exp_brd[cell_index(dir, l, k)] = mg[4*k +: 4];
        end
        exp_spawned = 0;
        exp_probes  = 16;
        if (exp_changed)
            for (int i = 0; i < 16; i++) begin
                int p;
                p = (int'(rn) + i) % 16;
                if (!exp_spawned && exp_brd[p] == 4'd0) begin
                    exp_brd[p]  = 4'd1;
                    exp_spawned = 1;
                    exp_probes  = i + 1;
                end
            end
        exp_win = 0;
        zero = 0;
        pair = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                v = exp_brd[r*4+c];
                if (v == 4'd11) exp_win = 1;
                if (v == 4'd0) zero = 1;
                if (c < 3 && v == exp_brd[r*4+c+1]) pair = 1;
                if (r < 3 && v == exp_brd[(r+1)*4+c]) pair = 1;
            end
        exp_lose = !exp_win && !zero && !pair;
    endtask

    function automatic logic [63:0] vec_of(input logic [3:0] b [16]);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = b[i];
        return r;
    endfunction

    task automatic load_board();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic random_board();
        for (int i = 0; i < 16; i++) init_brd[i] = 4'($urandom_range(0, 3));
        load_board();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {ifc.move_ready, ifc.cell_we, ifc.mrg_in_valid, ifc.mrg_out_ready,
                    ifc.done, ifc.changed, ifc.win, ifc.lose,
                    ifc.cell_addr, ifc.cell_wdata, ifc.mrg_in_line}, {8'b1000_0000, 24'd0});
    endtask

    task automatic do_move(input logic [1:0] dir, input logic [3:0] rn, input int stall);
        int n, we_start, exp_lat;
        @(negedge clk);
        model_move(dir, rn);
        check("ready_idle", ifc.move_ready, 1);
        ifc.rnd          = rn;
        stall_next       = stall;
        n_lines_seen     = 0;
        ifc.move_valid   = 1'b1;
        ifc.move_dir     = dir;
        we_start         = we_count;
        @(negedge clk);
        n = 1;
        ifc.move_dir = ~dir;
        while (ifc.done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
            if (n == 4) ifc.move_valid = 1'b0;
        end
        ifc.move_valid = 1'b0;
        exp_lat = 58 + stall + (exp_changed ? exp_probes : 0);
        check("latency", n, exp_lat);
        check("changed", ifc.changed, exp_changed);
        check("win", ifc.win, exp_win);
        check("lose", ifc.lose, exp_lose);
        check("board", vec_of(brd), vec_of(exp_brd));
        @(negedge clk);
        check("done_pulse", {ifc.done, ifc.move_ready}, 2'b01);
        check("flags_held", {ifc.changed, ifc.win, ifc.lose}, {exp_changed, exp_win, exp_lose});
        check("write_count", we_count - we_start, 16 + (exp_spawned ? 1 : 0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ifc.move_valid = 1'b0;
        ifc.move_dir   = 2'b00;
        ifc.rnd        = 4'd0;
        for (int i = 0; i < 16; i++) init_brd[i] = 4'd0;
        load_board();
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // LEFT, row0 = [1,1,2,0], rnd = 3
        for (int i = 0; i < 16; i++) init_brd[i] = 4'd0;
        init_brd[0] = 4'd1; init_brd[1] = 4'd1; init_brd[2] = 4'd2;
        load_board();
        do_move(2'b10, 4'd3, 0);
        check("left_row0", {brd[3], brd[2], brd[1], brd[0]}, 16'h1022);
        check("left_flags", {ifc.changed, ifc.win, ifc.lose}, 3'b100);

        // RIGHT, row0 = [1,0,0,0]: element 0 is col 3
        for (int i = 0; i < 16; i++) init_brd[i] = 4'd0;
        init_brd[0] = 4'd1;
        load_board();
        do_move(2'b11, 4'($urandom_range(0, 15)), 0);
        check("right_line0", first_line, 16'h1000);
        check("right_col3", {brd[3], 3'd0, ifc.changed}, {4'd1, 3'd0, 1'b1});

        // UP on a packed checkerboard: no change, no spawn, lose
        for (int i = 0; i < 16; i++) init_brd[i] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        load_board();
        do_move(2'b00, 4'($urandom_range(0, 15)), 0);
        check("packed_flags", {ifc.changed, ifc.win, ifc.lose}, 3'b001);

        // Same board with a winning tile
        init_brd[5] = 4'd11;
        load_board();
        do_move(2'b10, 4'($urandom_range(0, 15)), 0);
        check("win_flags", {ifc.changed, ifc.win, ifc.lose}, 3'b010);

        // Merge unit stalls mrg_in_ready for 7 cycles on the first line
        random_board();
        do_move(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 7);

        // Reset during WRITE of line 2 (cycles 27..30 after acceptance)
        random_board();
        @(negedge clk);
        ifc.move_valid = 1'b1;
        ifc.move_dir   = 2'b10;
        stall_next     = 0;
        @(negedge clk);
        ifc.move_valid = 1'b0;
        n = 1;
        while (n < 28) begin
            @(negedge clk);
            n++;
        end
        check("mid_write", ifc.cell_we, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ifc.move_ready, 1);
        do_move(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);

        for (int t = 0; t < 10; t++) begin
            random_board();
            do_move(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
